// File: rtl/d16_stack.sv
// Register-array data stack with pick port, sticky over/underflow flags and
// a one-cycle error pulse for any rejected operation.
module d16_stack #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [2:0]            i_op,
  input  logic [WIDTH-1:0]      i_data,
  input  logic [DEPTH_LOG2-1:0] i_pick,
  input  logic                  i_clr_err,
  output logic [WIDTH-1:0]      o_tos,
  output logic [WIDTH-1:0]      o_nos,
  output logic [WIDTH-1:0]      o_pick,
  output logic [DEPTH_LOG2:0]   o_depth,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_V = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE     = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] TWO     = (DEPTH_LOG2+1)'(2);

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_POP2    = 3'd3,
    OP_REPL    = 3'd4,
    OP_POPREPL = 3'd5,
    OP_SWAP    = 3'd6,
    OP_SETSP   = 3'd7
  } op_e;

  logic [WIDTH-1:0]      stack_q [DEPTH];
  logic [DEPTH_LOG2:0]   depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  err_q, err_d;

  op_e                   op;
  logic [DEPTH_LOG2-1:0] tos_idx, nos_idx, push_idx, pick_idx;
  logic [DEPTH_LOG2:0]   sp_val;
  logic                  pick_ok;
  logic                  rej_ovf, rej_unf;

  // Up to two entry writes per edge so SWAP completes in one cycle.
  logic                  wr0_en, wr1_en;
  logic [DEPTH_LOG2-1:0] wr0_idx, wr1_idx;
  logic [WIDTH-1:0]      wr0_data, wr1_data;

  always_comb begin
    op       = i_valid ? op_e'(i_op) : OP_NOP;
    tos_idx  = DEPTH_LOG2'(depth_q - ONE);
    nos_idx  = DEPTH_LOG2'(depth_q - TWO);
    push_idx = DEPTH_LOG2'(depth_q);
    pick_ok  = {1'b0, i_pick} < depth_q;
    pick_idx = DEPTH_LOG2'(depth_q - ONE - {1'b0, i_pick});
    sp_val   = i_data[DEPTH_LOG2:0];
  end

  always_comb begin
    depth_d  = depth_q;
    rej_ovf  = 1'b0;
    rej_unf  = 1'b0;
    wr0_en   = 1'b0;
    wr0_idx  = tos_idx;
    wr0_data = i_data;
    wr1_en   = 1'b0;
    wr1_idx  = nos_idx;
    wr1_data = stack_q[tos_idx];

    unique case (op)
      OP_PUSH: begin
        if (depth_q == DEPTH_V) rej_ovf = 1'b1;
        else begin
          wr0_en  = 1'b1;
          wr0_idx = push_idx;
          depth_d = depth_q + ONE;
        end
      end
      OP_POP: begin
        if (depth_q < ONE) rej_unf = 1'b1;
        else depth_d = depth_q - ONE;
      end
      OP_POP2: begin
        if (depth_q < TWO) rej_unf = 1'b1;
        else depth_d = depth_q - TWO;
      end
      OP_REPL: begin
        if (depth_q < ONE) rej_unf = 1'b1;
        else wr0_en = 1'b1;
      end
      OP_POPREPL: begin
        if (depth_q < TWO) rej_unf = 1'b1;
        else begin
          wr0_en  = 1'b1;
          wr0_idx = nos_idx;
          depth_d = depth_q - ONE;
        end
      end
      OP_SWAP: begin
        if (depth_q < TWO) rej_unf = 1'b1;
        else begin
          wr0_en   = 1'b1;
          wr0_data = stack_q[nos_idx];
          wr1_en   = 1'b1;
        end
      end
      OP_SETSP: begin
        if (sp_val > DEPTH_V) rej_ovf = 1'b1;
        else depth_d = sp_val;
      end
      default: ;
    endcase

    // Clear first so a same-cycle rejection re-sets its own flag.
    ovf_d = (ovf_q & ~i_clr_err) | rej_ovf;
    unf_d = (unf_q & ~i_clr_err) | rej_unf;
    err_d = rej_ovf | rej_unf;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (wr0_en) stack_q[wr0_idx] <= wr0_data;
      if (wr1_en) stack_q[wr1_idx] <= wr1_data;
    end
  end

  assign o_tos       = (depth_q >= ONE) ? stack_q[tos_idx] : '0;
  assign o_nos       = (depth_q >= TWO) ? stack_q[nos_idx] : '0;
  assign o_pick      = pick_ok ? stack_q[pick_idx] : '0;
  assign o_depth     = depth_q;
  assign o_empty     = (depth_q == '0);
  assign o_full      = (depth_q == DEPTH_V);
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_d16_stack.sv
// Bench for d16_stack: directed scenarios followed by random operations,
// all checked against an array-and-counter model of the stack.
module tb_d16_stack;

  localparam int W  = 16;
  localparam int DL = 6;
  localparam int D  = 64;

  logic          i_clk = 1'b0;
  logic          i_reset, i_valid, i_clr_err;
  logic [2:0]    i_op;
  logic [W-1:0]  i_data;
  logic [DL-1:0] i_pick;
  logic [W-1:0]  o_tos, o_nos, o_pick;
  logic [DL:0]   o_depth;
  logic          o_empty, o_full, o_overflow, o_underflow, o_err;

  d16_stack #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_op(i_op),
    .i_data(i_data), .i_pick(i_pick), .i_clr_err(i_clr_err),
    .o_tos(o_tos), .o_nos(o_nos), .o_pick(o_pick), .o_depth(o_depth),
    .o_empty(o_empty), .o_full(o_full), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  int m_mem [D];
  int m_depth;
  bit m_ovf, m_unf, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_read(input int pos);
    if (pos >= m_depth) return 0;
    return m_mem[m_depth - 1 - pos];
  endfunction

  task automatic model_step(input bit rst, input bit v, input int op, input int data, input bit clr);
    bit ro, ru;
    int o, t, sp;
    ro = 0; ru = 0;
    if (rst) begin
      m_depth = 0; m_ovf = 0; m_unf = 0; m_err = 0;
      return;
    end
    o = v ? op : 0;
    case (o)
      1: if (m_depth == D) ro = 1; else begin m_mem[m_depth] = data; m_depth++; end
      2: if (m_depth < 1) ru = 1; else m_depth -= 1;
      3: if (m_depth < 2) ru = 1; else m_depth -= 2;
      4: if (m_depth < 1) ru = 1; else m_mem[m_depth-1] = data;
      5: if (m_depth < 2) ru = 1; else begin m_mem[m_depth-2] = data; m_depth -= 1; end
      6: if (m_depth < 2) ru = 1;
         else begin
           t = m_mem[m_depth-1];
           m_mem[m_depth-1] = m_mem[m_depth-2];
           m_mem[m_depth-2] = t;
         end
      7: begin
        sp = data % (2 * D);
        if (sp > D) ro = 1; else m_depth = sp;
      end
      default: ;
    endcase
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (ro) m_ovf = 1;
    if (ru) m_unf = 1;
    m_err = ro | ru;
  endtask

  task automatic check_all();
    chk("depth", o_depth, m_depth);
    chk("tos", o_tos, m_read(0));
    chk("nos", o_nos, m_read(1));
    chk("pick", o_pick, m_read(int'(i_pick)));
    chk("empty", o_empty, m_depth == 0);
    chk("full", o_full, m_depth == D);
    chk("overflow", o_overflow, m_ovf);
    chk("underflow", o_underflow, m_unf);
    chk("err", o_err, m_err);
  endtask

  task automatic step(input bit rst, input bit v, input int op, input int data,
                      input bit clr, input int pick);
    int d16;
    d16 = data & 16'hFFFF;
    i_reset = rst; i_valid = v; i_op = op[2:0]; i_data = d16[W-1:0];
    i_clr_err = clr; i_pick = pick[DL-1:0];
    @(posedge i_clk);
    model_step(rst, v, op, d16, clr);
    #1;
    check_all();
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_op = '0; i_data = '0; i_clr_err = 1'b0; i_pick = '0;
    for (int k = 0; k < D; k++) m_mem[k] = 0;
    m_depth = 0; m_ovf = 0; m_unf = 0; m_err = 0;
    @(negedge i_clk);

    // Reset and basic push / pick
    step(1, 0, 0, 0, 0, 0);
    chk("rst_depth", o_depth, 0);
    step(0, 1, 1, 'h1111, 0, 0);
    step(0, 1, 1, 'h2222, 0, 1);
    chk("r35_depth", o_depth, 2);
    chk("r35_tos", o_tos, 'h2222);
    chk("r35_nos", o_nos, 'h1111);
    chk("r35_pick1", o_pick, 'h1111);
    i_pick = 2; #1;
    chk("r35_pick2", o_pick, 0);

    // SWAP, POPREPL, REPL
    step(0, 1, 6, 0, 0, 0);
    chk("r36_swap_tos", o_tos, 'h1111);
    chk("r36_swap_nos", o_nos, 'h2222);
    step(0, 1, 5, 'h3333, 0, 0);
    chk("r36_poprepl_depth", o_depth, 1);
    chk("r36_poprepl_tos", o_tos, 'h3333);
    step(0, 1, 4, 'h4444, 0, 0);
    chk("r36_repl_tos", o_tos, 'h4444);

    // Invalid strobe ignores the opcode
    step(0, 0, 1, 'h9999, 0, 0);
    chk("novalid_depth", o_depth, 1);

    // Fill to full, then overflow
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < D; k++) step(0, 1, 1, k, 0, k % D);
    chk("r37_full", o_full, 1);
    chk("r37_tos", o_tos, D - 1);
    step(0, 1, 1, 'hBEEF, 0, 0);
    chk("r37_err", o_err, 1);
    chk("r37_ovf", o_overflow, 1);
    chk("r37_depth", o_depth, D);
    chk("r37_tos_keep", o_tos, D - 1);
    step(0, 1, 0, 0, 0, D - 1);
    chk("r37_err_pulse", o_err, 0);
    chk("r37_pick_bottom", o_pick, 0);

    // Underflow at depth 1 / 0
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 'h0055, 0, 0);
    step(0, 1, 3, 0, 0, 0);
    chk("r38_unf", o_underflow, 1);
    chk("r38_err", o_err, 1);
    chk("r38_depth", o_depth, 1);
    step(0, 1, 2, 0, 0, 0);
    chk("r38_empty", o_empty, 1);
    chk("r38_tos0", o_tos, 0);
    step(0, 1, 2, 0, 0, 0);
    chk("r38_unf_stays", o_underflow, 1);
    chk("r38_depth0", o_depth, 0);

    // Clear-error interplay
    step(0, 1, 7, D + 1, 0, 0);
    chk("r39_ovf_set", o_overflow, 1);
    step(0, 1, 2, 0, 1, 0);
    chk("r39_ovf_clr", o_overflow, 0);
    chk("r39_unf_set", o_underflow, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("r39_ovf0", o_overflow, 0);
    chk("r39_unf0", o_underflow, 0);

    // SETSP and reset during a push
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 'hA0 + k, 0, 0);
    step(0, 1, 7, 3, 0, 0);
    chk("r40_depth", o_depth, 3);
    chk("r40_tos", o_tos, 'hA2);
    step(0, 1, 7, D + 1, 0, 0);
    chk("r40_ovf", o_overflow, 1);
    chk("r40_depth_keep", o_depth, 3);
    step(0, 1, 7, D, 0, 0);
    chk("setsp_full", o_full, 1);
    step(1, 1, 1, 'h7777, 0, 0);
    chk("r40_rst_depth", o_depth, 0);
    chk("r40_rst_ovf", o_overflow, 0);
    chk("r40_rst_unf", o_underflow, 0);

    // Random operations; storage already fully written above
    for (int n = 0; n < 2000; n++) begin
      int r_op, r_data;
      bit r_v, r_clr, r_rst;
      r_op   = $urandom_range(0, 7);
      r_v    = ($urandom_range(0, 9) != 0);
      r_clr  = ($urandom_range(0, 9) == 0);
      r_rst  = ($urandom_range(0, 199) == 0);
      r_data = (r_op == 7) ? $urandom_range(0, 2 * D - 1) : $urandom_range(0, 16'hFFFF);
      step(r_rst, r_v, r_op, r_data, r_clr, $urandom_range(0, D - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
